// File: rtl/timer_sequencer.sv
// Initiator-side sequencer for the fsm_timer START/RESET/READY handshake.
// Runs the timer for REPS back-to-back periods and guards the handshake with a watchdog.
`timescale 1ns/1ps
module timer_sequencer #(
  parameter int W       = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic         CLK,
  input  logic         N_RESET,
  input  logic         GO,
  input  logic [W-1:0] REPS,
  input  logic         ABORT,
  input  logic         READY,
  output logic         START,
  output logic         RESET,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR,
  output logic [W-1:0] DONE_CNT
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT, S_ACK, S_FINISH, S_ABORTING, S_FAULT
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   reps_q, reps_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           wdExpired;

  // The watchdog state lasts exactly TIMEOUT cycles before the fault transition.
  assign wdExpired = (wd_q == WDW'(TIMEOUT - 1));
  assign DONE_CNT  = cnt_q;

  always_comb begin
    state_d = state_q;
    reps_d  = reps_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (GO && (REPS != '0)) begin
          state_d = S_ARM;
          reps_d  = REPS;
          cnt_d   = '0;
        end
      end
      S_ARM: begin
        state_d = ABORT ? S_ABORTING : S_WAIT;
      end
      S_WAIT: begin
        if (ABORT)          state_d = S_ABORTING;
        else if (READY)     state_d = S_ACK;
        else if (wdExpired) state_d = S_FAULT;
      end
      S_ACK: begin
        if (ABORT) begin
          state_d = S_ABORTING;
        end else if (!READY) begin
          cnt_d   = cnt_q + W'(1);
          state_d = ((cnt_q + W'(1)) == reps_q) ? S_FINISH : S_ARM;
        end else if (wdExpired) begin
          state_d = S_FAULT;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      S_ABORTING: begin
        if (!READY)         state_d = S_IDLE;
        else if (wdExpired) state_d = S_FAULT;
      end
      S_FAULT: begin
        if (ABORT) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wd_d = '0;
    if ((state_d == state_q) &&
        (state_q inside {S_WAIT, S_ACK, S_ABORTING})) begin
      wd_d = wd_q + WDW'(1);
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q <= S_IDLE;
      reps_q  <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      START   <= 1'b0;
      RESET   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      state_q <= state_d;
      reps_q  <= reps_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      START   <= (state_d == S_ARM);
      RESET   <= (state_d inside {S_ACK, S_ABORTING, S_FAULT});
      BUSY    <= (state_d inside {S_ARM, S_WAIT, S_ACK, S_ABORTING});
      DONE    <= (state_d == S_FINISH);
      ERR     <= (state_d == S_FAULT);
    end
  end

endmodule

// File: tb/tb_timer_sequencer.sv
// Scoreboard bench for timer_sequencer driving a behavioural fsm_timer of length N.
`timescale 1ns/1ps
module tb_timer_sequencer;
  localparam int W       = 8;
  localparam int TIMEOUT = 16;
  localparam int N       = 4;

  localparam int EV_START    = 0;
  localparam int EV_DONE     = 1;
  localparam int EV_ERR      = 2;
  localparam int EV_ABORTEND = 3;

  logic         CLK = 1'b0;
  logic         N_RESET = 1'b0;
  logic         GO = 1'b0;
  logic [W-1:0] REPS = '0;
  logic         ABORT = 1'b0;
  logic         READY;
  logic         START, RESET, BUSY, DONE, ERR;
  logic [W-1:0] DONE_CNT;

  typedef struct {
    int kind;
    int cycle;
    int cnt;
  } ev_t;

  ev_t expQ[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  mode = 0;
  int  tCnt;
  logic tRun, tReady;

  timer_sequencer #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .N_RESET(N_RESET), .GO(GO), .REPS(REPS), .ABORT(ABORT),
    .READY(READY), .START(START), .RESET(RESET), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .DONE_CNT(DONE_CNT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Timer model: mode 0 normal, 1 READY tied low, 2 READY stuck high once raised.
  always @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      tReady <= 1'b0;
      tRun   <= 1'b0;
      tCnt   <= 0;
    end else if (mode == 1) begin
      tReady <= 1'b0;
      tRun   <= 1'b0;
    end else if (RESET && !(mode == 2 && tReady)) begin
      tReady <= 1'b0;
      tRun   <= 1'b0;
      tCnt   <= 0;
    end else if (START) begin
      tRun <= 1'b1;
      tCnt <= 1;
    end else if (tRun) begin
      if (tCnt == N - 2) begin
        tReady <= 1'b1;
        tRun   <= 1'b0;
      end else begin
        tCnt <= tCnt + 1;
      end
    end
  end
  assign READY = tReady;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic go, input int reps, input logic abort);
    GO    = go;
    REPS  = W'(reps);
    ABORT = abort;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pushEv(input int kind, input int c, input int cnt);
    ev_t e;
    e.kind  = kind;
    e.cycle = c;
    e.cnt   = cnt;
    expQ.push_back(e);
  endtask

  task automatic report(input int kind);
    ev_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_event: got kind=%0d cycle=%0d cnt=%0d, expected none",
               kind, cyc, int'(DONE_CNT));
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.cycle != cyc || e.cnt != int'(DONE_CNT)) begin
        errors++;
        $display("[TB] FAIL event: got kind=%0d cycle=%0d cnt=%0d, expected kind=%0d cycle=%0d cnt=%0d",
                 kind, cyc, int'(DONE_CNT), e.kind, e.cycle, e.cnt);
      end
    end
  endtask

  // Monitor: turns output activity into events and matches them against the queue.
  initial begin
    logic pBusy, pErr;
    pBusy = 1'b0;
    pErr  = 1'b0;
    forever begin
      @(negedge CLK);
      if (!N_RESET) begin
        pBusy = 1'b0;
        pErr  = 1'b0;
      end else begin
        checkOutput("start_reset_exclusive", int'(START && RESET), 0);
        if (START) report(EV_START);
        if (DONE) report(EV_DONE);
        if (ERR && !pErr) report(EV_ERR);
        if (pBusy && !BUSY && !DONE && !ERR) report(EV_ABORTEND);
        pBusy = BUSY;
        pErr  = ERR;
      end
    end
  end

  initial begin
    int g;
    #12;
    checkOutput("reset_start", int'(START), 0);
    checkOutput("reset_reset", int'(RESET), 0);
    checkOutput("reset_busy", int'(BUSY), 0);
    checkOutput("reset_done", int'(DONE), 0);
    checkOutput("reset_err", int'(ERR), 0);
    checkOutput("reset_done_cnt", int'(DONE_CNT), 0);
    @(posedge CLK);
    #1;
    N_RESET = 1'b1;
    repeat (3) tick();

    $display("[TB] normal run, REPS=3");
    g = cyc;
    pushEv(EV_START, g + 1, 0);
    pushEv(EV_START, g + 7, 1);
    pushEv(EV_START, g + 13, 2);
    pushEv(EV_DONE, g + 19, 3);
    applyStimulus(1'b1, 3, 1'b0);
    tick();
    applyStimulus(1'b0, 3, 1'b0);
    checkOutput("busy_first", int'(BUSY), 1);
    waitUntil(g + 18);
    checkOutput("busy_last", int'(BUSY), 1);
    waitUntil(g + 19);
    checkOutput("busy_in_done", int'(BUSY), 0);
    checkOutput("done_cnt_3", int'(DONE_CNT), 3);
    waitUntil(g + 22);

    $display("[TB] REPS=0 ignored, then GO held while busy");
    applyStimulus(1'b1, 0, 1'b0);
    tick();
    applyStimulus(1'b0, 0, 1'b0);
    tick();
    tick();
    checkOutput("reps0_busy", int'(BUSY), 0);
    checkOutput("reps0_done_cnt", int'(DONE_CNT), 3);
    g = cyc;
    pushEv(EV_START, g + 1, 0);
    pushEv(EV_START, g + 7, 1);
    pushEv(EV_DONE, g + 13, 2);
    applyStimulus(1'b1, 2, 1'b0);
    tick();
    applyStimulus(1'b1, 7, 1'b0);
    checkOutput("cnt_cleared", int'(DONE_CNT), 0);
    waitUntil(g + 10);
    applyStimulus(1'b0, 7, 1'b0);
    waitUntil(g + 16);

    $display("[TB] abort during second period");
    g = cyc;
    pushEv(EV_START, g + 1, 0);
    pushEv(EV_START, g + 7, 1);
    pushEv(EV_ABORTEND, g + 13, 1);
    applyStimulus(1'b1, 5, 1'b0);
    tick();
    applyStimulus(1'b0, 5, 1'b0);
    waitUntil(g + 10);
    applyStimulus(1'b0, 5, 1'b1);
    tick();
    applyStimulus(1'b0, 5, 1'b0);
    checkOutput("aborting_reset", int'(RESET), 1);
    checkOutput("aborting_busy", int'(BUSY), 1);
    waitUntil(g + 12);
    checkOutput("aborting_reset2", int'(RESET), 1);
    waitUntil(g + 13);
    checkOutput("abort_idle_reset", int'(RESET), 0);
    checkOutput("abort_done_cnt", int'(DONE_CNT), 1);
    waitUntil(g + 16);

    $display("[TB] READY tied low -> WAIT timeout");
    mode = 1;
    g = cyc;
    pushEv(EV_START, g + 1, 0);
    pushEv(EV_ERR, g + 18, 0);
    applyStimulus(1'b1, 1, 1'b0);
    tick();
    applyStimulus(1'b0, 1, 1'b0);
    waitUntil(g + 18);
    checkOutput("fault_err", int'(ERR), 1);
    checkOutput("fault_reset", int'(RESET), 1);
    checkOutput("fault_busy", int'(BUSY), 0);
    waitUntil(g + 20);
    applyStimulus(1'b1, 1, 1'b0);
    tick();
    tick();
    checkOutput("fault_go_ignored", int'(ERR), 1);
    applyStimulus(1'b0, 1, 1'b1);
    tick();
    applyStimulus(1'b0, 1, 1'b0);
    checkOutput("fault_cleared_err", int'(ERR), 0);
    checkOutput("fault_cleared_reset", int'(RESET), 0);
    mode = 0;
    waitUntil(g + 26);

    $display("[TB] READY stuck high -> ACK timeout");
    mode = 2;
    g = cyc;
    pushEv(EV_START, g + 1, 0);
    pushEv(EV_ERR, g + 21, 0);
    applyStimulus(1'b1, 2, 1'b0);
    tick();
    applyStimulus(1'b0, 2, 1'b0);
    waitUntil(g + 21);
    checkOutput("ack_fault_err", int'(ERR), 1);
    checkOutput("ack_fault_cnt", int'(DONE_CNT), 0);
    mode = 0;
    waitUntil(g + 23);
    applyStimulus(1'b0, 2, 1'b1);
    tick();
    applyStimulus(1'b0, 2, 1'b0);
    checkOutput("ack_fault_cleared", int'(ERR), 0);
    waitUntil(g + 27);

    $display("[TB] asynchronous reset mid-WAIT, then full run");
    g = cyc;
    pushEv(EV_START, g + 1, 0);
    applyStimulus(1'b1, 4, 1'b0);
    tick();
    applyStimulus(1'b0, 4, 1'b0);
    waitUntil(g + 3);
    #3;
    N_RESET = 1'b0;
    #1;
    checkOutput("async_busy", int'(BUSY), 0);
    checkOutput("async_reset", int'(RESET), 0);
    checkOutput("async_start", int'(START), 0);
    checkOutput("async_err", int'(ERR), 0);
    checkOutput("async_done_cnt", int'(DONE_CNT), 0);
    tick();
    tick();
    N_RESET = 1'b1;
    tick();
    g = cyc;
    pushEv(EV_START, g + 1, 0);
    pushEv(EV_START, g + 7, 1);
    pushEv(EV_START, g + 13, 2);
    pushEv(EV_START, g + 19, 3);
    pushEv(EV_DONE, g + 25, 4);
    applyStimulus(1'b1, 4, 1'b0);
    tick();
    applyStimulus(1'b0, 4, 1'b0);
    waitUntil(g + 25);
    checkOutput("rerun_done", int'(DONE), 1);
    checkOutput("rerun_busy", int'(BUSY), 0);
    waitUntil(g + 28);

    checkOutput("queue_empty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
